fetch_stage: RTL and testbench

//  Parametrised instruction-fetch stage for Core101; successor to the single-IR fetch path.

---
 rtl/fetch_stage.sv | 143 ++++++++++++++
 tb/tb_fetch_stage.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, keeps one memory request in flight and queues the
// returned instructions (with their PCs) for decode. A redirect flushes the queue.
module fetch_stage #(
    parameter int unsigned      XLEN         = 32,
    parameter logic [XLEN-1:0]  RESET_VECTOR = '0,
    parameter int unsigned      DEPTH        = 4
) (
    input  logic            fetch_stage_clock_in,
    input  logic            fetch_stage_reset_in,
    output logic            fetch_stage_mem_req_out,
    output logic [XLEN-1:0] fetch_stage_mem_addr_out,
    input  logic            fetch_stage_mem_gnt_in,
    input  logic            fetch_stage_mem_rvalid_in,
    input  logic [31:0]     fetch_stage_mem_data_in,
    input  logic            fetch_stage_redir_valid_in,
    input  logic [XLEN-1:0] fetch_stage_redir_target_in,
    output logic            fetch_stage_ins_valid_out,
    input  logic            fetch_stage_ins_ready_in,
    output logic [31:0]     fetch_stage_ins_data_out,
    output logic [XLEN-1:0] fetch_stage_ins_pc_out
);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        ST_ISSUE   = 2'd0,
        ST_WAIT    = 2'd1,
        ST_DISCARD = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [XLEN-1:0]   req_pc_q, req_pc_d;
    logic              req_q, req_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [31:0]       data_mem_q [DEPTH];
    logic [XLEN-1:0]   pc_mem_q   [DEPTH];

    logic              granted;
    logic              push;
    logic              pop;
    logic              ins_valid;

    assign ins_valid = (count_q != '0);

    // Next-state: fetch FSM, PC, FIFO bookkeeping; redirect overrides everything last.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        req_pc_d = req_pc_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        push     = 1'b0;
        granted  = req_q && fetch_stage_mem_gnt_in;
        pop      = ins_valid && fetch_stage_ins_ready_in;

        unique case (state_q)
            ST_ISSUE: begin
                if (granted) begin
                    state_d  = ST_WAIT;
                    req_pc_d = pc_q;
                    pc_d     = pc_q + XLEN'(4);
                end
            end
            ST_WAIT: begin
                if (fetch_stage_mem_rvalid_in) begin
                    state_d = ST_ISSUE;
                    push    = 1'b1;
                end
            end
            ST_DISCARD: begin
                if (fetch_stage_mem_rvalid_in) begin
                    state_d = ST_ISSUE;
                end
            end
            default: state_d = ST_ISSUE;
        endcase

        if (fetch_stage_redir_valid_in) begin
            push = 1'b0;
            pc_d = fetch_stage_redir_target_in & ~XLEN'(3);
            if (state_q == ST_ISSUE) begin
                state_d = granted ? ST_DISCARD : ST_ISSUE;
            end else begin
                state_d = fetch_stage_mem_rvalid_in ? ST_ISSUE : ST_DISCARD;
            end
        end

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        count_d = count_q + CNT_W'(push) - CNT_W'(pop);

        if (fetch_stage_redir_valid_in) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end

        req_d = (state_d == ST_ISSUE) && (count_d < DEPTH_CNT);
    end

    always_ff @(posedge fetch_stage_clock_in or negedge fetch_stage_reset_in) begin
        if (!fetch_stage_reset_in) begin
            state_q  <= ST_ISSUE;
            pc_q     <= RESET_VECTOR;
            req_pc_q <= '0;
            req_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                data_mem_q[i] <= '0;
                pc_mem_q[i]   <= '0;
            end
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            req_pc_q <= req_pc_d;
            req_q    <= req_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (push) begin
                data_mem_q[wr_ptr_q] <= fetch_stage_mem_data_in;
                pc_mem_q[wr_ptr_q]   <= req_pc_q;
            end
        end
    end

    assign fetch_stage_mem_req_out   = req_q;
    assign fetch_stage_mem_addr_out  = pc_q;
    assign fetch_stage_ins_valid_out = ins_valid;
    assign fetch_stage_ins_data_out  = data_mem_q[rd_ptr_q];
    assign fetch_stage_ins_pc_out    = pc_mem_q[rd_ptr_q];

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: reactive memory, random decode/redirect traffic and a queue-based
// model of the fetched instruction stream, checked every cycle plus directed scenarios.
module tb_fetch_stage;
    localparam int unsigned XLEN  = 32;
    localparam int unsigned DEPTH = 4;
    localparam logic [31:0] RV    = 32'h0000_0080;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        gnt = 1'b0, rvalid = 1'b0, redir = 1'b0, ready = 1'b0;
    logic [31:0] rdata = '0, target = '0;
    logic        req, valid;
    logic [31:0] addr, idata, ipc;

    fetch_stage #(.XLEN(XLEN), .RESET_VECTOR(RV), .DEPTH(DEPTH)) dut (
        .fetch_stage_clock_in        (clk),
        .fetch_stage_reset_in        (rst_n),
        .fetch_stage_mem_req_out     (req),
        .fetch_stage_mem_addr_out    (addr),
        .fetch_stage_mem_gnt_in      (gnt),
        .fetch_stage_mem_rvalid_in   (rvalid),
        .fetch_stage_mem_data_in     (rdata),
        .fetch_stage_redir_valid_in  (redir),
        .fetch_stage_redir_target_in (target),
        .fetch_stage_ins_valid_out   (valid),
        .fetch_stage_ins_ready_in    (ready),
        .fetch_stage_ins_data_out    (idata),
        .fetch_stage_ins_pc_out      (ipc)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
    } ent_t;

    // Model: expected instruction queue, PC, and the single in-flight fetch.
    ent_t        m_q[$];
    logic [31:0] m_pc, m_req_pc;
    bit          m_busy, m_keep;

    // Memory responder state.
    bit          mem_pend;
    int          mem_cnt;
    logic [31:0] mem_addr;

    int g_gnt_pct, g_rdy_pct, g_redir_pct, g_kmin, g_kmax;
    bit g_spur;
    bit f_redir;
    logic [31:0] f_target;

    int n_checks, n_fail;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
    endfunction

    function automatic bit roll(input int pct);
        return ($urandom_range(99) < pct);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cfg(input int gp, input int rp, input int dp, input int kmin, input int kmax,
                       input bit spur);
        g_gnt_pct = gp; g_rdy_pct = rp; g_redir_pct = dp;
        g_kmin = kmin; g_kmax = kmax; g_spur = spur;
    endtask

    // One cycle: compare at negedge, drive inputs, advance the model, wait for next negedge.
    task automatic step();
        bit m_req, m_valid, granted, pop;
        m_req   = !m_busy && (m_q.size() < DEPTH);
        m_valid = (m_q.size() > 0);
        chk("req",   32'(req),   32'(m_req));
        chk("addr",  addr,       m_pc);
        chk("valid", 32'(valid), 32'(m_valid));
        if (m_valid) begin
            chk("data", idata, m_q[0].data);
            chk("pc",   ipc,   m_q[0].pc);
        end

        rvalid = 1'b0;
        rdata  = $urandom;
        if (mem_pend) begin
            mem_cnt--;
            if (mem_cnt == 0) begin
                rvalid   = 1'b1;
                rdata    = mem_word(mem_addr);
                mem_pend = 1'b0;
            end
        end else if (g_spur && $urandom_range(15) == 0) begin
            rvalid = 1'b1;
        end
        gnt    = roll(g_gnt_pct) && !mem_pend;
        ready  = roll(g_rdy_pct);
        redir  = f_redir || roll(g_redir_pct);
        target = f_redir ? f_target : ($urandom & 32'h0000_0FFF);
        f_redir = 1'b0;

        granted = m_req && gnt;
        if (granted) begin
            mem_pend = 1'b1;
            mem_cnt  = int'($urandom_range(g_kmax, g_kmin));
            mem_addr = m_pc;
        end

        pop = m_valid && ready;
        if (pop) m_q.delete(0);
        if (redir) begin
            m_q.delete();
            m_pc = target & ~32'h3;
            if (m_busy) begin
                if (rvalid) m_busy = 1'b0;
                else        m_keep = 1'b0;
            end else if (granted) begin
                m_busy = 1'b1;
                m_keep = 1'b0;
            end
        end else if (m_busy && rvalid) begin
            if (m_keep) m_q.push_back('{pc: m_req_pc, data: rdata});
            m_busy = 1'b0;
        end else if (granted) begin
            m_busy   = 1'b1;
            m_keep   = 1'b1;
            m_req_pc = m_pc;
            m_pc     = m_pc + 32'd4;
        end
        @(negedge clk);
    endtask

    // Asynchronous reset mid-cycle; memory keeps any in-flight response.
    task automatic do_reset();
        rst_n = 1'b0;
        gnt = 1'b0; rvalid = 1'b0; redir = 1'b0; ready = 1'b0;
        #1;
        chk("rst_req",   32'(req),   32'd0);
        chk("rst_addr",  addr,       RV);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_data",  idata,      32'd0);
        chk("rst_pc",    ipc,        32'd0);
        m_q.delete();
        m_pc   = RV;
        m_busy = 1'b0;
        m_keep = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic wait_valid(input string name, input logic [31:0] exp_pc);
        int i;
        i = 0;
        while (!valid && i < 20) begin
            step();
            i++;
        end
        chk({name, "_valid"}, 32'(valid), 32'd1);
        chk({name, "_pc"},    ipc,        exp_pc);
    endtask

    initial begin
        n_checks = 0; n_fail = 0;
        f_redir = 1'b0; f_target = '0;
        mem_pend = 1'b0; mem_cnt = 0; mem_addr = '0;
        m_pc = RV; m_req_pc = '0; m_busy = 1'b0; m_keep = 1'b0;
        cfg(0, 0, 0, 1, 1, 0);
        @(negedge clk);
        do_reset();

        // Idle memory: request held at the reset vector.
        cfg(0, 100, 0, 1, 1, 0);
        repeat (3) step();
        chk("t1_req",   32'(req),   32'd1);
        chk("t1_addr",  addr,       32'h80);
        chk("t1_valid", 32'(valid), 32'd0);

        // Back-to-back fetches, one-cycle memory.
        cfg(100, 100, 0, 1, 1, 0);
        step(); step();
        chk("t2_valid0", 32'(valid), 32'd1);
        chk("t2_pc0",    ipc,        32'h80);
        chk("t2_data0",  idata,      mem_word(32'h80));
        step();
        chk("t2_gap",    32'(valid), 32'd0);
        step();
        chk("t2_pc1",    ipc,        32'h84);
        step(); step();
        chk("t2_pc2",    ipc,        32'h88);
        chk("t2_data2",  idata,      mem_word(32'h88));

        // Full FIFO stalls fetch, then drains.
        do_reset();
        cfg(100, 0, 0, 1, 1, 0);
        repeat (12) step();
        chk("t3_req_full", 32'(req), 32'd0);
        chk("t3_head",     ipc,      32'h80);
        chk("t3_addr",     addr,     32'h90);
        cfg(100, 100, 0, 1, 1, 0);
        step();
        chk("t3_resume_req",  32'(req), 32'd1);
        chk("t3_resume_addr", addr,     32'h90);
        repeat (12) step();

        // Redirect while waiting on memory with two entries queued.
        do_reset();
        cfg(100, 0, 0, 1, 1, 0);
        repeat (4) step();
        cfg(100, 0, 0, 3, 3, 0);
        step();
        f_redir = 1'b1; f_target = 32'h200;
        step();
        chk("t4_valid", 32'(valid), 32'd0);
        chk("t4_addr",  addr,       32'h200);
        chk("t4_req",   32'(req),   32'd0);
        cfg(100, 100, 0, 1, 1, 0);
        wait_valid("t4_first", 32'h200);

        // Redirect coinciding with a grant and a pop; target is unaligned.
        do_reset();
        cfg(100, 0, 0, 1, 1, 0);
        step(); step();
        chk("t5_head", ipc, 32'h80);
        cfg(100, 100, 0, 1, 1, 0);
        f_redir = 1'b1; f_target = 32'h103;
        step();
        chk("t5_addr",  addr,       32'h100);
        chk("t5_valid", 32'(valid), 32'd0);
        wait_valid("t5_first", 32'h100);

        // PC wrap, then reset with a response still in flight.
        do_reset();
        cfg(0, 0, 0, 1, 1, 0);
        f_redir = 1'b1; f_target = 32'hFFFF_FFFC;
        step();
        chk("t6_addr_top", addr, 32'hFFFF_FFFC);
        cfg(100, 0, 0, 5, 5, 0);
        step();
        chk("t6_addr_wrap", addr, 32'h0000_0000);
        cfg(0, 0, 0, 1, 1, 0);
        step(); step();
        do_reset();
        cfg(100, 100, 0, 1, 1, 0);
        repeat (3) step();
        chk("t6_late_valid", 32'(valid), 32'd0);
        wait_valid("t6_after", 32'h80);

        // Randomised traffic with occasional resets.
        for (int b = 0; b < 6; b++) begin
            cfg(60, (b % 3 == 0) ? 90 : ((b % 3 == 1) ? 15 : 60), 4, 1, 3, 1);
            for (int c = 0; c < 500; c++) begin
                if ($urandom_range(999) == 0) do_reset();
                step();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
